keypad_scanner: RTL and testbench

Scans a 4x4 active-low key matrix and delivers debounced key-press events to the control logic through a valid/ack holding register. The column drive is multiplexed one column at a time, and rows are sampled per column. It is the input-side counterpart of the multiplexed 7-segment digit driver: the same time-division scan, but reading a matrix instead of lighting one. The block sits between the board keypad pins and the value-entry logic that feeds the display.

---
 rtl/keypad_scanner.sv | 205 ++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: one-hot column drive, per-scan classification,
// debounced press/release FSM and a valid/ack event register. Auto-repeat when KEYPAD_REPEAT_EN is defined.
module keypad_scanner #(
  parameter int SCAN_PERIOD    = 100000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_down,
  output logic       overflow
);

  localparam int CW = (SCAN_PERIOD > 3) ? $clog2(SCAN_PERIOD) : 2;
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(SCAN_PERIOD - 1);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} result_t;
  typedef enum logic {ST_RELEASED, ST_PRESSED} state_t;

  if (SCAN_PERIOD < 3) begin : g_bad_scan_period
    $error("keypad_scanner: SCAN_PERIOD must be at least 3");
  end
  if (DEBOUNCE_SCANS < 1) begin : g_bad_debounce
    $error("keypad_scanner: DEBOUNCE_SCANS must be at least 1");
  end
  if (REPEAT_SCANS < 1) begin : g_bad_repeat
    $error("keypad_scanner: REPEAT_SCANS must be at least 1");
  end

  logic [3:0]    r_row_meta, r_row_sync;
  logic [CW-1:0] r_cyc_cnt;
  logic [1:0]    r_col_idx;
  logic [15:0]   r_samples;
  logic [15:0]   w_samples_now;
  logic          w_sample, w_scan_end;
  logic [4:0]    w_hits;
  logic [3:0]    w_hit_code;
  result_t       w_result, r_prev_result;
  logic [3:0]    r_prev_code;
  logic [DW-1:0] r_stable_cnt, w_stable_next;
  logic          w_same, w_stable;
  state_t        r_state, w_state_next;
  logic          w_event, w_repeat_fire;
  logic [3:0]    w_event_code;
  logic [3:0]    r_key_code;
  logic          r_key_valid, r_overflow;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row_meta <= 4'hF;
      r_row_sync <= 4'hF;
    end else begin
      r_row_meta <= row_in;
      r_row_sync <= r_row_meta;
    end
  end

  assign w_sample   = (r_cyc_cnt == CYC_LAST);
  assign w_scan_end = w_sample && (r_col_idx == 2'd3);
  assign col_out    = ~(4'b0001 << r_col_idx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cyc_cnt <= '0;
      r_col_idx <= 2'd0;
    end else if (w_sample) begin
      r_cyc_cnt <= '0;
      r_col_idx <= r_col_idx + 2'd1;
    end else begin
      r_cyc_cnt <= r_cyc_cnt + 1'b1;
    end
  end

  // Bit row*4+col holds a closure; the column being sampled now is taken live.
  for (genvar gi = 0; gi < 16; gi++) begin : g_sample
    assign w_samples_now[gi] = (r_col_idx == 2'(gi % 4)) ? ~r_row_sync[gi / 4] : r_samples[gi];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_samples <= '0;
    else if (w_sample)
      r_samples <= w_samples_now;
  end

  always_comb begin
    w_hits     = 5'd0;
    w_hit_code = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (w_samples_now[i]) begin
        w_hits     = w_hits + 5'd1;
        w_hit_code = 4'(i);
      end
    end
    if (w_hits == 5'd0)
      w_result = RES_NONE;
    else if (w_hits == 5'd1)
      w_result = RES_SINGLE;
    else
      w_result = RES_MULTI;
  end

  assign w_same = (w_result == r_prev_result) &&
                  ((w_result != RES_SINGLE) || (w_hit_code == r_prev_code));
  assign w_stable_next = !w_same ? DW'(1) :
                         (r_stable_cnt == DEB_MAX) ? DEB_MAX : r_stable_cnt + 1'b1;
  assign w_stable = (w_stable_next == DEB_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev_result <= RES_NONE;
      r_prev_code   <= 4'd0;
      r_stable_cnt  <= '0;
    end else if (w_scan_end) begin
      r_prev_result <= w_result;
      r_prev_code   <= w_hit_code;
      r_stable_cnt  <= w_stable_next;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_SCANS - 1);
  logic [RW-1:0] r_rep_cnt;
  logic [3:0]    r_press_code;
  logic          w_rep_match;

  assign w_rep_match   = (r_state == ST_PRESSED) && (w_result == RES_SINGLE) &&
                         (w_hit_code == r_press_code);
  assign w_repeat_fire = w_scan_end && w_rep_match && (r_rep_cnt == REP_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rep_cnt    <= '0;
      r_press_code <= 4'd0;
    end else if (w_scan_end) begin
      if ((r_state == ST_RELEASED) || !w_rep_match || w_repeat_fire)
        r_rep_cnt <= '0;
      else
        r_rep_cnt <= r_rep_cnt + 1'b1;
      if (r_state == ST_RELEASED)
        r_press_code <= w_hit_code;
    end
  end
`else
  assign w_repeat_fire = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= ST_RELEASED;
    else
      r_state <= w_state_next;
  end

  // MULTI and non-matching SINGLE results fall through without touching state.
  always_comb begin
    w_state_next = r_state;
    w_event      = 1'b0;
    w_event_code = w_hit_code;
    if (w_scan_end && w_stable) begin
      case (r_state)
        ST_RELEASED: if (w_result == RES_SINGLE) begin
          w_state_next = ST_PRESSED;
          w_event      = 1'b1;
        end
        ST_PRESSED: if (w_result == RES_NONE)
          w_state_next = ST_RELEASED;
        default: w_state_next = ST_RELEASED;
      endcase
    end
    if (w_repeat_fire)
      w_event = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (w_event) begin
      if (!r_key_valid || key_ack) begin
        r_key_code  <= w_event_code;
        r_key_valid <= 1'b1;
      end else begin
        r_overflow  <= 1'b1;
      end
    end else if (key_ack) begin
      r_key_valid <= 1'b0;
    end
  end

  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign overflow  = r_overflow;
  assign key_down  = (r_state == ST_PRESSED);

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a behavioural 4x4 key matrix and an event scoreboard.
module tb_keypad_scanner;
  localparam int SCAN = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        key_ack = 1'b0;
  logic [3:0]  row_in;
  logic [3:0]  col_out, key_code;
  logic        key_valid, key_down, overflow;
  logic [15:0] keys = '0;
  logic [3:0]  exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  // A closed key pulls its row low while its column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      row_in[r] = ~|(keys[r*4 +: 4] & ~col_out);
  end

  keypad_scanner #(.SCAN_PERIOD(4), .DEBOUNCE_SCANS(3), .REPEAT_SCANS(5)) dut (
    .clk(clk), .reset(reset), .row_in(row_in), .col_out(col_out), .key_code(key_code),
    .key_valid(key_valid), .key_ack(key_ack), .key_down(key_down), .overflow(overflow)
  );

  task automatic align_scan();
    logic [3:0] prev;
    bit found;
    prev  = col_out;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (col_out == 4'b1110 && prev == 4'b0111) found = 1;
      prev = col_out;
    end
    if (!found) begin
      n_vec++; n_err++;
      $display("FAIL align_scan: col_out=%b never wrapped to 1110", col_out);
    end
  endtask

  // Waits for key_valid, checks latency, then pops the scoreboard and compares the code.
  task automatic wait_event(input string name, input int exp_lat);
    int n;
    logic [3:0] exp_code;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (key_valid !== 1'b1 && n < 150);
    n_vec++;
    if (key_valid !== 1'b1) begin
      n_err++;
      $display("FAIL %s timeout: key_valid=%b after %0d cycles, required 1", name, key_valid, n);
      return;
    end
    if (n != exp_lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d cycles, required %0d", name, n, exp_lat);
    end
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s code: event code=%0d with empty scoreboard", name, key_code);
    end else begin
      exp_code = exp_q.pop_front();
      if (key_code !== exp_code) begin
        n_err++;
        $display("FAIL %s code: got %0d, required %0d", name, key_code, exp_code);
      end
      $display("event %s code=%0d after %0d cycles", name, key_code, n);
    end
    n_vec++;
    if (key_down !== 1'b1) begin
      n_err++;
      $display("FAIL %s key_down: got %b, required 1", name, key_down);
    end
  endtask

  task automatic wait_down(input string name, input logic level, input int exp_lat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (key_down !== level && n < 150);
    n_vec++;
    if (key_down !== level) begin
      n_err++;
      $display("FAIL %s timeout: key_down=%b, required %b", name, key_down, level);
    end else if (exp_lat > 0 && n != exp_lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d cycles, required %0d", name, n, exp_lat);
    end else begin
      $display("key_down=%b %s after %0d cycles", level, name, n);
    end
  endtask

  task automatic expect_quiet(input string name, input int cycles, input bit allow_down);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      n_vec++;
      if (key_valid !== 1'b0 || (!allow_down && key_down !== 1'b0)) begin
        n_err++;
        $display("FAIL %s cycle %0d: key_valid=%b key_down=%b, required 0", name, i, key_valid, key_down);
      end
    end
  endtask

  task automatic check_reset_values(input string name);
    n_vec++;
    if (col_out !== 4'b1110 || key_valid !== 1'b0 || key_down !== 1'b0 ||
        overflow !== 1'b0 || key_code !== 4'd0) begin
      n_err++;
      $display("FAIL %s: col=%b valid=%b down=%b ovf=%b code=%0d, required 1110/0/0/0/0",
               name, col_out, key_valid, key_down, overflow, key_code);
    end else begin
      $display("%s: reset values ok", name);
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) @(negedge clk);
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      n_vec++;
      if (col_out !== exp_col) begin
        n_err++;
        $display("FAIL col_step %0d: got %b, required %b", k, col_out, exp_col);
      end
    end
    $display("column stepping checked over 17 cycles");
  endtask

  task automatic test_single_press();
    align_scan();
    keys[9] = 1'b1;
    exp_q.push_back(4'd9);
    wait_event("press9", 3 * SCAN);
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
    n_vec++;
    if (key_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ack_clear: key_valid=%b, required 0", key_valid);
    end
    expect_quiet("hold9", 31, 1'b1);
    keys[9] = 1'b0;
    wait_down("release9", 1'b0, 3 * SCAN);
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 100; i++) begin
      if (i % 20 == 0) keys[9] = ~keys[9];
      expect_quiet("bounce", 1, 1'b0);
    end
    keys = '0;
    expect_quiet("bounce_release", 4 * SCAN, 1'b0);
  endtask

  task automatic test_multi();
    align_scan();
    keys[0] = 1'b1;
    keys[5] = 1'b1;
    expect_quiet("multi", 6 * SCAN, 1'b0);
    keys = '0;
    expect_quiet("multi_release", 4 * SCAN, 1'b0);
  endtask

  task automatic test_overflow();
    align_scan();
    keys[3] = 1'b1;
    exp_q.push_back(4'd3);
    wait_event("press3", 3 * SCAN);
    keys[3] = 1'b0;
    wait_down("release3", 1'b0, -1);
    keys[12] = 1'b1;
    wait_down("press12", 1'b1, -1);
    @(negedge clk);
    n_vec++;
    if (key_code !== 4'd3 || overflow !== 1'b1 || key_valid !== 1'b1) begin
      n_err++;
      $display("FAIL overflow_drop: code=%0d ovf=%b valid=%b, required 3/1/1", key_code, overflow, key_valid);
    end
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
    n_vec++;
    if (key_valid !== 1'b0 || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL overflow_ack: valid=%b ovf=%b, required 0/1", key_valid, overflow);
    end
    keys[12] = 1'b0;
    wait_down("release12", 1'b0, -1);
  endtask

  task automatic test_reset_mid_press();
    align_scan();
    keys[9] = 1'b1;
    repeat (24) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("reset_mid");
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(4'd9);
    wait_event("press9_after_reset", 3 * SCAN);
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
    keys[9] = 1'b0;
    wait_down("release9b", 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_multi();
    test_overflow();
    test_reset_mid_press();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: %0d events outstanding, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
